// File: rtl/rom_read_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rom_arb_pkg
// Shared types and helpers for the ROM read arbiter.
//   - arb_state_t    : arbiter FSM states (IDLE, READ, WAIT)
//   - req_idx_t      : requester index, wide enough for up to MAX_REQ requesters
//   - DEF_*          : default widths / depth used as module parameter defaults
//   - next_rr_winner : round-robin pick over a zero-padded request vector
// -----------------------------------------------------------------------------
package rom_arb_pkg;

    localparam int DEF_MEM_ADDR_SIZE = 3;
    localparam int DEF_DATA_WIDTH    = 4;
    localparam int DEF_MEM_DEPTH     = 8;
    localparam int DEF_NUM_REQ       = 2;
    localparam int MAX_REQ           = 8;
    localparam int IDX_W             = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    typedef logic [IDX_W-1:0] req_idx_t;

    // Scan upward from ptr+1, wrapping at MAX_REQ. Requesters above NUM_REQ are
    // zero-padded, so wrapping at MAX_REQ gives the same order as wrapping at
    // NUM_REQ: the just-served requester (ptr) is always checked last.
    function automatic req_idx_t next_rr_winner(input logic [MAX_REQ-1:0] req,
                                                input req_idx_t           ptr);
        req_idx_t idx;
        req_idx_t win;
        logic     found;
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            idx = ptr + req_idx_t'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rom_read_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector.
// Ports:
//   req     in   NUM_REQ  request vector
//   ptr     in   IDX_W    index of the requester served last
//   winner  out  IDX_W    index of the selected requester (valid when any_req)
//   any_req out  1        at least one request is pending
// -----------------------------------------------------------------------------
module rr_pick
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any_req
);

    logic [MAX_REQ-1:0] req_ext;

    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req;
    end

    assign winner  = next_rr_winner(req_ext, ptr);
    assign any_req = |req;

endmodule

// File: rtl/rom_read_arbiter.sv
// -----------------------------------------------------------------------------
// rom_read_arbiter
// Round-robin arbiter sharing one single-port synchronous ROM (1-cycle
// registered read) between NUM_REQ requesters. Each read takes three cycles:
// grant + address issue, ROM sample, data capture + response pulse.
//
// Optional build macro: ROM_ARB_ADDR_CHECK_EN
//   defined   : addresses >= MEM_DEPTH skip the ROM access and respond with
//               rsp_data=0, rsp_err=1 on the normal response cycle.
//   undefined : addresses pass to the ROM unchecked; rsp_err is always 0.
//
// Ports:
//   clk        in   1                      clock, rising edge
//   rst        in   1                      async active-low reset
//   req_valid  in   NUM_REQ                per-requester read request
//   req_addr   in   NUM_REQ*MEM_ADDR_SIZE  flattened request addresses
//   req_gnt    out  NUM_REQ                one-hot grant pulse
//   rsp_valid  out  NUM_REQ                one-hot response pulse
//   rsp_data   out  DATA_WIDTH             read data, held between responses
//   rsp_err    out  1                      address-range error (with rsp_valid)
//   rom_en     out  1                      ROM read enable
//   rom_addr   out  MEM_ADDR_SIZE          ROM address
//   rom_data   in   DATA_WIDTH             ROM registered read data
// -----------------------------------------------------------------------------
module rom_read_arbiter
    import rom_arb_pkg::*;
#(
    parameter int MEM_ADDR_SIZE = DEF_MEM_ADDR_SIZE,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int MEM_DEPTH     = DEF_MEM_DEPTH,
    parameter int NUM_REQ       = DEF_NUM_REQ
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*MEM_ADDR_SIZE-1:0]   req_addr,
    output logic [NUM_REQ-1:0]                 req_gnt,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    output logic [DATA_WIDTH-1:0]              rsp_data,
    output logic                               rsp_err,
    output logic                               rom_en,
    output logic [MEM_ADDR_SIZE-1:0]           rom_addr,
    input  logic [DATA_WIDTH-1:0]              rom_data
);

    if (MEM_DEPTH > (1 << MEM_ADDR_SIZE)) begin : g_bad_depth
        $error("rom_read_arbiter: MEM_DEPTH exceeds the address space");
    end
    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
        $error("rom_read_arbiter: NUM_REQ must be 2..8");
    end

    arb_state_t               state, state_d;
    req_idx_t                 ptr, ptr_d;
    req_idx_t                 owner, owner_d;
    logic                     bad_q, bad_d;
    logic [NUM_REQ-1:0]       req_gnt_d, rsp_valid_d;
    logic [DATA_WIDTH-1:0]    rsp_data_d;
    logic                     rsp_err_d;
    logic                     rom_en_d;
    logic [MEM_ADDR_SIZE-1:0] rom_addr_d;

    req_idx_t                 winner;
    logic                     any_req;
    logic [NUM_REQ-1:0]       win_oh, own_oh;
    logic [MEM_ADDR_SIZE-1:0] sel_addr;
    logic                     sel_bad;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req     (req_valid),
        .ptr     (ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    // Only the winner's address slice is ever selected, so X on losing
    // requesters' addresses never reaches the ROM.
    always_comb begin
        win_oh   = '0;
        own_oh   = '0;
        sel_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == req_idx_t'(i)) begin
                win_oh[i] = 1'b1;
                sel_addr  = req_addr[i*MEM_ADDR_SIZE +: MEM_ADDR_SIZE];
            end
            if (owner == req_idx_t'(i)) begin
                own_oh[i] = 1'b1;
            end
        end
    end

`ifdef ROM_ARB_ADDR_CHECK_EN
    assign sel_bad = (int'(sel_addr) >= MEM_DEPTH);
`else
    assign sel_bad = 1'b0;
`endif

    always_comb begin
        state_d     = state;
        ptr_d       = ptr;
        owner_d     = owner;
        bad_d       = bad_q;
        req_gnt_d   = '0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data;
        rsp_err_d   = rsp_err;
        rom_en_d    = 1'b0;
        rom_addr_d  = rom_addr;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    owner_d    = winner;
                    ptr_d      = winner;
                    bad_d      = sel_bad;
                    req_gnt_d  = win_oh;
                    rom_addr_d = sel_addr;
                    // An out-of-range read never touches the ROM.
                    rom_en_d   = !sel_bad;
                    state_d    = READ;
                end
            end
            READ: begin
                state_d = WAIT;
            end
            WAIT: begin
                rsp_valid_d = own_oh;
                rsp_data_d  = bad_q ? '0 : rom_data;
                rsp_err_d   = bad_q;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= req_idx_t'(NUM_REQ - 1);
            owner     <= '0;
            bad_q     <= 1'b0;
            req_gnt   <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            rom_en    <= 1'b0;
            rom_addr  <= '0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            owner     <= owner_d;
            bad_q     <= bad_d;
            req_gnt   <= req_gnt_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            rsp_err   <= rsp_err_d;
            rom_en    <= rom_en_d;
            rom_addr  <= rom_addr_d;
        end
    end

endmodule
